// File: rtl/loop_seq_ctrl.sv
// rtl/loop_seq_ctrl.sv - nested-loop sequencer driving stride-walker loop events
//
// Purpose: stores per-level iteration counts, then walks the loop nest level by level.
// It emits init/enter/iterate/exit events on a shared loop-index bus and ends each
// nest with a single-cycle loop_ctrl_done pulse.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   cfg_loop_iter_v   write one level's count (iterations-1), outermost level first
//   cfg_loop_iter     iteration count minus one for the next level
//   start             begin walking the programmed nest
//   stall             freeze the sequencer; event outputs read 0 while frozen
//   busy              high from the first event through the done pulse
//   loop_index        level the current event refers to
//   loop_index_valid  one iteration step at loop_index (ITER or STEP)
//   loop_init         nest initialisation pulse
//   loop_enter        entering level loop_index
//   loop_exit         level loop_index finished
//   loop_ctrl_done    whole nest complete
module loop_seq_ctrl #(
    parameter int LOOP_ID_W = 5,
    parameter int ITER_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_loop_iter_v,
    input  logic [ITER_W-1:0]    cfg_loop_iter,
    input  logic                 start,
    input  logic                 stall,
    output logic                 busy,
    output logic [LOOP_ID_W-1:0] loop_index,
    output logic                 loop_index_valid,
    output logic                 loop_init,
    output logic                 loop_enter,
    output logic                 loop_exit,
    output logic                 loop_ctrl_done
);

    localparam int DEPTH = 2 ** LOOP_ID_W;

    typedef enum logic [2:0] {IDLE, INIT, ENTER, ITER, EXIT, STEP, DONE} state_t;

    // The state register names the event that will be emitted on the next
    // non-stalled edge, so each event lands in the output registers on the same
    // edge its state is executed. This gives loop_init the cycle after start.
    state_t               state;
    logic [LOOP_ID_W-1:0] cur_lvl;
    logic [LOOP_ID_W:0]   num_lvl;
    logic [ITER_W-1:0]    iter_mem [DEPTH];
    logic [ITER_W-1:0]    cnt      [DEPTH];

    logic [LOOP_ID_W-1:0] prev_lvl;
    logic                 last_lvl;
    logic                 cfg_ok;

    assign prev_lvl = cur_lvl - LOOP_ID_W'(1);
    assign last_lvl = ({1'b0, cur_lvl} == num_lvl - (LOOP_ID_W+1)'(1));
    // The top bit of num_lvl set means the table is full.
    assign cfg_ok   = cfg_loop_iter_v && (state == IDLE) && !start && !num_lvl[LOOP_ID_W];

    always_ff @(posedge clk) begin
        if (cfg_ok)
            iter_mem[num_lvl[LOOP_ID_W-1:0]] <= cfg_loop_iter;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cur_lvl          <= '0;
            num_lvl          <= '0;
            for (int i = 0; i < DEPTH; i++)
                cnt[i] <= '0;
            busy             <= 1'b0;
            loop_index       <= '0;
            loop_index_valid <= 1'b0;
            loop_init        <= 1'b0;
            loop_enter       <= 1'b0;
            loop_exit        <= 1'b0;
            loop_ctrl_done   <= 1'b0;
        end else begin
            if (cfg_ok)
                num_lvl <= num_lvl + (LOOP_ID_W+1)'(1);

            loop_index       <= '0;
            loop_index_valid <= 1'b0;
            loop_init        <= 1'b0;
            loop_enter       <= 1'b0;
            loop_exit        <= 1'b0;
            loop_ctrl_done   <= 1'b0;

            if (!stall) begin
                busy <= 1'b1;
                case (state)
                    IDLE: begin
                        if (!start) begin
                            busy <= 1'b0;
                        end else if (num_lvl == '0) begin
                            // Empty nest: the done event is emitted straight away.
                            loop_ctrl_done <= 1'b1;
                        end else begin
                            loop_init <= 1'b1;
                            cur_lvl   <= '0;
                            state     <= ENTER;
                        end
                    end
                    INIT: begin
                        loop_init <= 1'b1;
                        cur_lvl   <= '0;
                        state     <= ENTER;
                    end
                    ENTER: begin
                        loop_enter   <= 1'b1;
                        loop_index   <= cur_lvl;
                        cnt[cur_lvl] <= '0;
                        if (last_lvl)
                            state <= ITER;
                        else
                            cur_lvl <= cur_lvl + LOOP_ID_W'(1);
                    end
                    ITER: begin
                        loop_index_valid <= 1'b1;
                        loop_index       <= cur_lvl;
                        if (cnt[cur_lvl] == iter_mem[cur_lvl])
                            state <= EXIT;
                        else
                            cnt[cur_lvl] <= cnt[cur_lvl] + ITER_W'(1);
                    end
                    EXIT: begin
                        loop_exit  <= 1'b1;
                        loop_index <= cur_lvl;
                        if (cur_lvl == '0) begin
                            state <= DONE;
                        end else begin
                            // A finished outer level cascades into another exit.
                            cur_lvl <= prev_lvl;
                            if (cnt[prev_lvl] != iter_mem[prev_lvl])
                                state <= STEP;
                        end
                    end
                    STEP: begin
                        loop_index_valid <= 1'b1;
                        loop_index       <= cur_lvl;
                        cnt[cur_lvl]     <= cnt[cur_lvl] + ITER_W'(1);
                        cur_lvl          <= cur_lvl + LOOP_ID_W'(1);
                        state            <= ENTER;
                    end
                    DONE: begin
                        loop_ctrl_done <= 1'b1;
                        num_lvl        <= '0;
                        state          <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
